// File: rtl/fpga2host_fifo.sv
// fpga2host_fifo: DEPTH x DW buffer on the FPGA->host path feeding spi_interface.
// Producer side is a plain write strobe (no backpressure); consumer side is an
// AXI-Stream master with per-word tlast. The registered RAM read lands directly
// in the output stage, so a push is visible on m_tvalid two cycles later.
// Optional feature macro: FPGA2HOST_FIFO_HWM_EN adds hwm and ovf_seen outputs.
module fpga2host_fifo #(
    parameter int DEPTH = 512,
    parameter int DW    = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_last,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tlast,
    output logic [CW-1:0] fpga2host_fifo_filled,
    output logic          err_outfifo_overflow_pulse,
    input  logic          flush
`ifdef FPGA2HOST_FIFO_HWM_EN
    ,
    output logic [CW-1:0] hwm,
    output logic          ovf_seen
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Storage: word plus its last flag in the top bit
    logic [DW:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;      // RAM + output stage
    logic [CW-1:0]  ram_cnt;    // words still sitting in RAM
    logic [CW-1:0]  count_nxt;

    logic           vld_p1;
    logic [DW-1:0]  data_p1;
    logic           last_p1;
    logic           ovf_p1;

    logic           push_ok;
    logic           push_ovf;
    logic           pop;
    logic           rd_issue;

    // Push is judged against the count before any same-cycle pop; flush swallows pushes silently
    always_comb begin
        push_ok   = wr_en && (count != FULL) && !flush;
        push_ovf  = wr_en && (count == FULL) && !flush;
        pop       = vld_p1 && m_tready;
        rd_issue  = (ram_cnt != '0) && (!vld_p1 || pop);
        count_nxt = count + CW'(push_ok) - CW'(pop);
    end

    // RAM write port; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {wr_last, wr_data};
    end

    // Stage p1: registered RAM read loads the output stage directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
        end else if (rd_issue) begin
            vld_p1             <= 1'b1;
            {last_p1, data_p1} <= mem[rd_ptr];
        end else if (pop) begin
            vld_p1  <= 1'b0;
        end
    end

    // Pointers, occupancy counters and the overflow pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ram_cnt <= '0;
            ovf_p1  <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ram_cnt <= '0;
            ovf_p1  <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(push_ok);
            rd_ptr  <= rd_ptr + AW'(rd_issue);
            count   <= count_nxt;
            ram_cnt <= ram_cnt + CW'(push_ok) - CW'(rd_issue);
            ovf_p1  <= push_ovf;
        end
    end

`ifdef FPGA2HOST_FIFO_HWM_EN
    // High-water mark tracks the count as it is registered; sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm      <= '0;
            ovf_seen <= 1'b0;
        end else if (flush) begin
            hwm      <= '0;
            ovf_seen <= 1'b0;
        end else begin
            if (count_nxt > hwm)
                hwm <= count_nxt;
            if (push_ovf)
                ovf_seen <= 1'b1;
        end
    end
`endif

    assign m_tvalid                   = vld_p1;
    assign m_tdata                    = data_p1;
    assign m_tlast                    = last_p1;
    assign fpga2host_fifo_filled      = count;
    assign err_outfifo_overflow_pulse = ovf_p1;

endmodule

// File: tb/tb_fpga2host_fifo.sv
// Directed testbench for fpga2host_fifo: ordering, latency, full/overflow,
// wrap-around streaming, stall stability, reset and flush.
module tb_fpga2host_fifo;

    localparam int DEPTH = 512;
    localparam int DW    = 32;
    localparam int CW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          wr_last;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic [CW-1:0] filled;
    logic          ovf;
    logic          flush;
`ifdef FPGA2HOST_FIFO_HWM_EN
    logic [CW-1:0] hwm;
    logic          ovf_seen;
`endif

    int checks = 0;
    int errors = 0;

    fpga2host_fifo #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .wr_en                      (wr_en),
        .wr_data                    (wr_data),
        .wr_last                    (wr_last),
        .m_tvalid                   (m_tvalid),
        .m_tready                   (m_tready),
        .m_tdata                    (m_tdata),
        .m_tlast                    (m_tlast),
        .fpga2host_fifo_filled      (filled),
        .err_outfifo_overflow_pulse (ovf),
        .flush                      (flush)
`ifdef FPGA2HOST_FIFO_HWM_EN
        ,
        .hwm                        (hwm),
        .ovf_seen                   (ovf_seen)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Push/pop stream with a queue scoreboard; steady mode also checks 1 word/clk and flat fill
    task automatic run_stream(input int n, input int push_pct, input int rdy_pct, input bit steady);
        logic [DW:0]   q[$];
        logic [DW:0]   e;
        int            pushed = 0;
        int            got = 0;
        int            cyc = 0;
        logic          pv = 1'b0;
        logic          pr = 1'b1;
        logic [DW-1:0] pd = '0;
        logic          pl = 1'b0;
        while (got < n && cyc < 20000) begin
            if (pv && !pr) begin
                chk("hold_vld", 64'(m_tvalid), 64'd1);
                chk("hold_data", 64'(m_tdata), 64'(pd));
                chk("hold_last", 64'(m_tlast), 64'(pl));
            end
            if (steady && cyc >= 2 && cyc < n) begin
                chk("steady_vld", 64'(m_tvalid), 64'd1);
                chk("steady_filled", 64'(filled), 64'd2);
            end
            m_tready = ($urandom_range(99) < rdy_pct);
            if (m_tvalid && m_tready) begin
                if (q.size() == 0) begin
                    chk("stream_spurious", 64'(m_tvalid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("stream_data", 64'(m_tdata), 64'(e[DW-1:0]));
                    chk("stream_last", 64'(m_tlast), 64'(e[DW]));
                end
                got++;
            end
            wr_en = (pushed < n) && ($urandom_range(99) < push_pct);
            if (wr_en) begin
                wr_data = $urandom;
                wr_last = 1'($urandom_range(1));
                q.push_back({wr_last, wr_data});
                pushed++;
            end
            pv = m_tvalid; pr = m_tready; pd = m_tdata; pl = m_tlast;
            tick();
            cyc++;
        end
        wr_en = 1'b0;
        m_tready = 1'b0;
        chk("stream_words", 64'(got), 64'(n));
        chk("stream_empty_vld", 64'(m_tvalid), 64'd0);
        chk("stream_empty_filled", 64'(filled), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] t1 [3];
        t1[0] = 32'h0100_0000; t1[1] = 32'h0; t1[2] = 32'h0;
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; wr_last = 1'b0; m_tready = 1'b0; flush = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_vld", 64'(m_tvalid), 64'd0);
        chk("rst_data", 64'(m_tdata), 64'd0);
        chk("rst_last", 64'(m_tlast), 64'd0);
        chk("rst_filled", 64'(filled), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        tick();

        // Three pushes, last on the third; m_tvalid rises two cycles after the first push
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = t1[i]; wr_last = (i == 2);
            tick();
            chk("t1_filled", 64'(filled), 64'(i + 1));
            if (i == 0) chk("t1_lat_n1", 64'(m_tvalid), 64'd0);
            if (i == 1) chk("t1_lat_n2", 64'(m_tvalid), 64'd1);
        end
        wr_en = 1'b0; wr_last = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t1_vld", 64'(m_tvalid), 64'd1);
            chk("t1_data", 64'(m_tdata), 64'(t1[i]));
            chk("t1_last", 64'(m_tlast), 64'(i == 2));
            tick();
            chk("t1_drain_filled", 64'(filled), 64'(2 - i));
        end
        chk("t1_vld_end", 64'(m_tvalid), 64'd0);
        m_tready = 1'b0;

        // Fill to DEPTH, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_data = 32'hA000_0000 + DW'(i); wr_last = (i == DEPTH - 1);
            tick();
        end
        chk("full_filled", 64'(filled), 64'(DEPTH));
        chk("full_ovf_pre", 64'(ovf), 64'd0);
        wr_data = 32'hDEAD_DEAD; wr_last = 1'b0;
        tick();
        chk("ovf_pulse", 64'(ovf), 64'd1);
        chk("ovf_filled", 64'(filled), 64'(DEPTH));
        wr_en = 1'b0;
        tick();
        chk("ovf_one_cycle", 64'(ovf), 64'd0);
        chk("ovf_filled2", 64'(filled), 64'(DEPTH));
`ifdef FPGA2HOST_FIFO_HWM_EN
        chk("ovf_seen_set", 64'(ovf_seen), 64'd1);
        chk("hwm_full", 64'(hwm), 64'(DEPTH));
`endif

        // Push and pop together while full: push still overflows
        wr_en = 1'b1; wr_data = 32'hBEEF_BEEF; m_tready = 1'b1;
        chk("full_pp_data", 64'(m_tdata), 64'h0A000_0000);
        tick();
        wr_en = 1'b0;
        chk("full_pp_ovf", 64'(ovf), 64'd1);
        chk("full_pp_filled", 64'(filled), 64'(DEPTH - 1));
        for (int i = 1; i < DEPTH; i++) begin
            if (i == 2) chk("full_pp_ovf_clr", 64'(ovf), 64'd0);
            chk("drain_vld", 64'(m_tvalid), 64'd1);
            chk("drain_data", 64'(m_tdata), 64'(32'hA000_0000 + DW'(i)));
            chk("drain_last", 64'(m_tlast), 64'(i == DEPTH - 1));
            tick();
        end
        chk("drain_vld_end", 64'(m_tvalid), 64'd0);
        chk("drain_filled_end", 64'(filled), 64'd0);
        m_tready = 1'b0;

        // Continuous stream across pointer wrap, then random stalls
        run_stream(2000, 100, 100, 1'b1);
        run_stream(1000, 50, 50, 1'b0);

        // Asynchronous reset with 100 words queued
        for (int i = 0; i < 100; i++) begin
            wr_en = 1'b1; wr_data = DW'(i); wr_last = 1'b0;
            tick();
        end
        wr_en = 1'b0;
        chk("pre_rst_filled", 64'(filled), 64'd100);
        rst = 1'b1;
        #1;
        chk("rst_mid_vld", 64'(m_tvalid), 64'd0);
        chk("rst_mid_filled", 64'(filled), 64'd0);
        tick();
        rst = 1'b0; m_tready = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_vld", 64'(m_tvalid), 64'd0);
        chk("post_rst_filled", 64'(filled), 64'd0);
`ifdef FPGA2HOST_FIFO_HWM_EN
        chk("post_rst_ovf_seen", 64'(ovf_seen), 64'd0);
        chk("post_rst_hwm", 64'(hwm), 64'd0);
`endif
        m_tready = 1'b0;

        // Flush with 100 words queued
        for (int i = 0; i < 100; i++) begin
            wr_en = 1'b1; wr_data = DW'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("pre_flush_filled", 64'(filled), 64'd100);
`ifdef FPGA2HOST_FIFO_HWM_EN
        chk("pre_flush_hwm", 64'(hwm), 64'd100);
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_vld", 64'(m_tvalid), 64'd0);
        chk("flush_filled", 64'(filled), 64'd0);
`ifdef FPGA2HOST_FIFO_HWM_EN
        chk("flush_hwm", 64'(hwm), 64'd0);
`endif

        // Flush while full with a push in the same cycle: no overflow pulse
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_data = DW'(i);
            tick();
        end
        chk("refill_filled", 64'(filled), 64'(DEPTH));
        flush = 1'b1; wr_en = 1'b1;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        chk("flush_full_ovf", 64'(ovf), 64'd0);
        chk("flush_full_filled", 64'(filled), 64'd0);
        chk("flush_full_vld", 64'(m_tvalid), 64'd0);
        m_tready = 1'b1;
        tick();
        chk("flush_full_ovf2", 64'(ovf), 64'd0);
        chk("flush_full_vld2", 64'(m_tvalid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
